// File: rtl/uart_host_sched.sv
// uart_host_sched: the only master of the UART core's CPU port.
// The scheduler polls STATUS and moves received bytes into a small
// first-word-fall-through FIFO. It also round-robin shares the TX register
// between NREQ byte-stream requesters. A pending RX byte always wins over TX.
module uart_host_sched #(
    parameter int NREQ     = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rx_valid,
    output logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              uart_wr,
    output logic [1:0]        uart_addr,
    output logic [7:0]        uart_wdata,
    input  logic [7:0]        uart_rdata,
    output logic [15:0]       tx_count,
    output logic [15:0]       rx_count
);
    localparam int GW = $clog2(NREQ);
    localparam int PW = $clog2(RX_DEPTH);

    localparam logic [1:0] ADDR_TX     = 2'd0;
    localparam logic [1:0] ADDR_RX     = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    typedef enum logic [1:0] {POLL, RX_READ, TX_WRITE} state_t;

    state_t        state, state_d;
    logic [GW-1:0] grant, grant_d, rr_ptr, arb_idx;
    logic          arb_hit;

    logic [7:0]    fifo_mem [RX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   fifo_cnt;
    logic          fifo_full, push, pop;

    assign fifo_full = (fifo_cnt == (PW+1)'(RX_DEPTH));
    assign rx_valid  = (fifo_cnt != '0);
    assign rx_data   = rx_valid ? fifo_mem[rd_ptr] : 8'h00;
    assign push      = (state == RX_READ);
    assign pop       = rx_valid && rx_ready;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        arb_idx = '0;
        arb_hit = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!arb_hit && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                arb_hit = 1'b1;
                arb_idx = GW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    // Next-state decision: POLL samples STATUS this cycle; RX beats TX.
    always_comb begin
        state_d = state;
        grant_d = grant;
        case (state)
            POLL: begin
                if (en && uart_rdata[0] && !fifo_full) begin
                    state_d = RX_READ;
                end else if (en && !uart_rdata[1] && arb_hit) begin
                    state_d = TX_WRITE;
                    grant_d = arb_idx;
                end
            end
            default: state_d = POLL;
        endcase
    end

    // Core port decode from registered state and grant only.
    always_comb begin
        uart_wr    = 1'b0;
        uart_addr  = ADDR_STATUS;
        uart_wdata = 8'h00;
        req_ready  = '0;
        case (state)
            RX_READ: begin
                uart_wr   = 1'b1;
                uart_addr = ADDR_RX;
            end
            TX_WRITE: begin
                uart_wr          = 1'b1;
                uart_addr        = ADDR_TX;
                uart_wdata       = req_data[int'(grant)*8 +: 8];
                req_ready[grant] = 1'b1;
            end
            default: ;
        endcase
    end

    // FSM, grant, round-robin pointer and byte counters.
    always_ff @(posedge clk) begin
        // NOTE: registered state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) begin
            state    <= POLL;
            grant    <= '0;
            rr_ptr   <= '0;
            tx_count <= '0;
            rx_count <= '0;
        end else begin
            state <= state_d;
            grant <= grant_d;
            if (state == TX_WRITE) begin
                tx_count <= tx_count + 16'd1;
                rr_ptr   <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
            end
            if (state == RX_READ) begin
                rx_count <= rx_count + 16'd1;
            end
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage: the byte read from the core lands at the RX_READ edge.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; emptiness comes from fifo_cnt and rx_data is masked while empty.
        if (push) fifo_mem[wr_ptr] <= uart_rdata;
    end
endmodule

// File: tb/tb_uart_host_sched.sv
// Bench for uart_host_sched: behavioural UART core CPU port, requester
// driver, and scoreboards for TX writes and RX FIFO pops.
module tb_uart_host_sched;
    localparam int NREQ        = 4;
    localparam int RX_DEPTH    = 4;
    localparam int TX_BUSY_CYC = 25;
    localparam int TMO         = 2000;

    logic              clk = 1'b0;
    logic              rstn, en, rx_ready;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [8*NREQ-1:0] req_data;
    logic              rx_valid, uart_wr;
    logic [7:0]        rx_data, uart_wdata, uart_rdata;
    logic [1:0]        uart_addr;
    logic [15:0]       tx_count, rx_count;

    always #5 clk = ~clk;

    uart_host_sched #(.NREQ(NREQ), .RX_DEPTH(RX_DEPTH)) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .uart_wr(uart_wr), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
        .uart_rdata(uart_rdata), .tx_count(tx_count), .rx_count(rx_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural core: RX ready flag cleared by an RX access, TX busy window after a write.
    logic       core_rx_flag  = 1'b0;
    logic [7:0] core_rx_byte  = 8'h00;
    int         core_busy_cnt = 0;
    logic       core_busy;
    logic       inj_valid;
    logic [7:0] inj_byte;

    assign core_busy = (core_busy_cnt != 0);

    always @(posedge clk) begin
        if (uart_wr && uart_addr == 2'd1) core_rx_flag <= 1'b0;
        if (inj_valid) begin
            core_rx_flag <= 1'b1;
            core_rx_byte <= inj_byte;
        end
        if (uart_wr && uart_addr == 2'd0) core_busy_cnt <= TX_BUSY_CYC;
        else if (core_busy_cnt != 0)      core_busy_cnt <= core_busy_cnt - 1;
    end

    always_comb begin
        case (uart_addr)
            2'd1:    uart_rdata = core_rx_byte;
            2'd2:    uart_rdata = {6'd0, core_busy, core_rx_flag};
            default: uart_rdata = 8'h00;
        endcase
    end

    // Scoreboards
    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] data;
    } tx_exp_t;

    tx_exp_t    exp_tx[$];
    logic [7:0] exp_rx[$];

    // Per-requester byte streams
    logic [7:0] tx_buf  [NREQ][8];
    int         tx_head [NREQ];
    int         tx_tail [NREQ];

    task automatic push_tx(input int i, input logic [7:0] b);
        tx_exp_t e;
        tx_buf[i][tx_tail[i] % 8] = b;
        tx_tail[i]++;
        e.idx  = 8'(i);
        e.data = b;
        exp_tx.push_back(e);
    endtask

    // Requester driver: hold valid/data through the accept cycle, advance after it.
    logic [NREQ-1:0] acc;
    initial begin
        req_valid = '0;
        req_data  = '0;
        acc       = '0;
        for (int i = 0; i < NREQ; i++) begin
            tx_head[i] = 0;
            tx_tail[i] = 0;
        end
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) tx_head[i]++;
                acc[i] = req_ready[i];
                if (!acc[i]) begin
                    req_valid[i] = (tx_head[i] != tx_tail[i]);
                    req_data[8*i +: 8] = req_valid[i] ? tx_buf[i][tx_head[i] % 8] : 8'h00;
                end
            end
        end
    end

    // Monitor: compares every TX write and every FIFO pop against the scoreboards.
    int cyc = 0;
    int last_rx_cyc = -1;
    int last_tx_cyc = -1;
    int ready_cycles = 0;
    int wr_cycles = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        tx_exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (req_ready != '0) ready_cycles++;
            if (uart_wr) wr_cycles++;
            if (uart_wr && uart_addr == 2'd0) begin
                last_tx_cyc = cyc;
                check("tx_to_busy_core", 32'(core_busy), 32'd0);
                if (exp_tx.size() == 0) begin
                    check("tx_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_tx.pop_front();
                    check("tx_wdata", 32'(uart_wdata), 32'(e.data));
                    check("tx_req_ready", 32'(req_ready), 32'd1 << e.idx);
                end
            end
            if (uart_wr && uart_addr == 2'd1) last_rx_cyc = cyc;
            if (rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
                else                    check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
            end
        end
    end

    // Stimulus helpers (all called at a falling edge)
    task automatic inject(input logic [7:0] b, input bit track);
        @(negedge clk);
        inj_byte  = b;
        inj_valid = 1'b1;
        if (track) exp_rx.push_back(b);
        @(negedge clk);
        inj_valid = 1'b0;
    endtask

    task automatic wait_rx_taken(input string name);
        bit done = 0;
        for (int k = 0; k < TMO && !done; k++) begin
            @(negedge clk);
            if (!core_rx_flag) done = 1;
        end
        if (!done) check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_tx_idle(input string name);
        bit done = 0;
        for (int k = 0; k < TMO && !done; k++) begin
            @(negedge clk);
            if (exp_tx.size() == 0 && !core_busy && !uart_wr && req_valid == '0) done = 1;
        end
        if (!done) check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_access(input string name, input logic [1:0] addr);
        bit done = 0;
        for (int k = 0; k < TMO && !done; k++) begin
            @(negedge clk);
            if (uart_wr && uart_addr == addr) done = 1;
        end
        if (!done) check(name, 32'd0, 32'd1);
    endtask

    task automatic drain(input string name, input int n);
        int pops = 0;
        bit done = 0;
        rx_ready = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            if (rx_valid) pops++;
            else          done = 1;
            if (!done) @(negedge clk);
        end
        rx_ready = 1'b0;
        check(name, 32'(pops), 32'(n));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Watchdog
    initial begin
        #(500_000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Directed tests
    initial begin
        int rise_cyc;
        int wr_before;
        rstn      = 1'b0;
        en        = 1'b1;
        rx_ready  = 1'b0;
        inj_valid = 1'b0;
        inj_byte  = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_uart_wr",    32'(uart_wr),    32'd0);
        check("rst_uart_addr",  32'(uart_addr),  32'd2);
        check("rst_uart_wdata", 32'(uart_wdata), 32'd0);
        check("rst_req_ready",  32'(req_ready),  32'd0);
        check("rst_rx_valid",   32'(rx_valid),   32'd0);
        check("rst_rx_data",    32'(rx_data),    32'd0);
        check("rst_tx_count",   32'(tx_count),   32'd0);
        check("rst_rx_count",   32'(rx_count),   32'd0);
        rstn = 1'b1;

        // Single requester 0 sends 0x55 to an idle core.
        @(negedge clk);
        push_tx(0, 8'h55);
        wait_tx_idle("t1_timeout");
        check("t1_tx_count",     32'(tx_count), 32'd1);
        check("t1_ready_cycles", 32'(ready_cycles), 32'd1);
        check("t1_wr_cycles",    32'(wr_cycles), 32'd1);

        // en=0 holds the scheduler in POLL with RX and TX both pending.
        en = 1'b0;
        push_tx(2, 8'hE2);
        inject(8'hE0, 1'b1);
        wr_before = wr_cycles;
        repeat (10) @(negedge clk);
        check("en0_no_access", 32'(wr_cycles - wr_before), 32'd0);
        check("en0_rx_flag",   32'(core_rx_flag), 32'd1);
        en       = 1'b1;
        rx_ready = 1'b1;
        wait_tx_idle("en1_timeout");
        repeat (3) @(negedge clk);
        rx_ready = 1'b0;
        check("en1_rx_count", 32'(rx_count), 32'd1);
        check("en1_tx_count", 32'(tx_count), 32'd2);

        // All four requesters valid at once: order 0,1,2,3,0.
        pulse_reset();
        push_tx(0, 8'hA0);
        push_tx(1, 8'hA1);
        push_tx(2, 8'hA2);
        push_tx(3, 8'hA3);
        push_tx(0, 8'hA4);
        wait_tx_idle("t2_timeout");
        check("t2_tx_count", 32'(tx_count), 32'd5);

        // RX byte and requester 1 pending together: RX_READ first.
        inject(8'h3C, 1'b1);
        push_tx(1, 8'h77);
        rise_cyc = -100;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            if (rx_valid) begin
                rise_cyc = cyc;
                break;
            end
        end
        wait_tx_idle("t3_timeout");
        check("t3_rx_before_tx",  32'(last_tx_cyc - last_rx_cyc), 32'd2);
        check("t3_rx_valid_rise", 32'(rise_cyc - last_rx_cyc), 32'd1);
        check("t3_rx_valid",      32'(rx_valid), 32'd1);
        check("t3_rx_data",       32'(rx_data), 32'h3C);
        check("t3_rx_count",      32'(rx_count), 32'd1);
        drain("t3_pops", 1);

        // Fill the FIFO; the fifth byte has to wait in the core.
        for (int b = 1; b <= 4; b++) begin
            inject(8'(b), 1'b1);
            wait_rx_taken("t4_fill_timeout");
        end
        inject(8'h05, 1'b1);
        repeat (10) @(negedge clk);
        check("t4_byte5_held", 32'(core_rx_flag), 32'd1);
        check("t4_rx_count",   32'(rx_count), 32'd5);
        check("t4_head",       32'(rx_data), 32'h01);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        wait_rx_taken("t4_byte5_timeout");
        check("t4_rx_count2", 32'(rx_count), 32'd6);
        @(negedge clk);
        drain("t4_pops", 4);

        // Push and pop on the same edge at 3/4 full.
        for (int b = 0; b < 3; b++) begin
            inject(8'(8'h10 + b), 1'b1);
            wait_rx_taken("t5_fill_timeout");
        end
        inject(8'h13, 1'b1);
        wait_access("t5_read_timeout", 2'd1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("t5_head", 32'(rx_data), 32'h11);
        drain("t5_pops", 3);
        check("t5_rx_count", 32'(rx_count), 32'd10);

        // Reset during TX_WRITE with the FIFO non-empty.
        inject(8'h99, 1'b0);
        wait_rx_taken("t6_rx_timeout");
        wait_tx_idle("t6_idle_timeout");
        push_tx(2, 8'hC2);
        wait_access("t6_write_timeout", 2'd0);
        rstn = 1'b0;
        @(negedge clk);
        check("t6_uart_wr",   32'(uart_wr),   32'd0);
        check("t6_uart_addr", 32'(uart_addr), 32'd2);
        check("t6_rx_valid",  32'(rx_valid),  32'd0);
        check("t6_req_ready", 32'(req_ready), 32'd0);
        check("t6_tx_count",  32'(tx_count),  32'd0);
        check("t6_rx_count",  32'(rx_count),  32'd0);
        rstn = 1'b1;
        wait_tx_idle("t6_busy_timeout");
        push_tx(0, 8'hD0);
        push_tx(3, 8'hD3);
        wait_tx_idle("t6_grant_timeout");
        check("t6_tx_count2", 32'(tx_count), 32'd2);

        check("end_tx_queue", 32'(exp_tx.size()), 32'd0);
        check("end_rx_queue", 32'(exp_rx.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
